// File: rtl/ecc_ehc_scrubber.sv
// Background SECDED scrubber: walks every address, rewrites
// single-bit errors with corrected data/EDC, flags double errors.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_enable, i_start    scrub allowed / skip the remaining period wait
//   o_mem_req/we/addr    RAM request (held stable until i_mem_gnt)
//   o_mem_wdata/wedc     write-back data and full EDC
//   i_mem_gnt            request accepted this cycle
//   i_mem_rvalid/rdata/redc  read response (any latency >= 1 after gnt)
//   o_busy               FSM outside IDLE/WAIT
//   o_pass_done          pulse after the last address is scrubbed
//   o_corr_count/o_uncorr_count  saturating error counters
//   o_uncorr_irq/o_uncorr_addr   pulse and address per uncorrectable word
module ecc_ehc_scrubber #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_WIDTH    = 16,
    // r is either clog2(DATA_WIDTH+1) or one more; EDC adds the overall parity bit
    localparam int R0          = $clog2(DATA_WIDTH + 1),
    localparam int EDC_WIDTH   = ((2 ** R0 >= DATA_WIDTH + R0 + 1) ? R0 : R0 + 1) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [EDC_WIDTH-1:0]  o_mem_wedc,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic [EDC_WIDTH-1:0]  i_mem_redc,
    output logic                  o_busy,
    output logic                  o_pass_done,
    output logic [CNT_WIDTH-1:0]  o_corr_count,
    output logic [CNT_WIDTH-1:0]  o_uncorr_count,
    output logic                  o_uncorr_irq,
    output logic [ADDR_WIDTH-1:0] o_uncorr_addr
);

    localparam int R  = EDC_WIDTH - 1;
    localparam int N  = DATA_WIDTH + R;
    localparam int PW = $clog2(SCRUB_PERIOD + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCRUB_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR_REQ,
        S_NEXT
    } state_t;

    // Codeword position of data bit idx: the idx-th non-power-of-2 position.
    function automatic int pos_of(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    // Hamming parity bits are the XOR of the positions of all set data bits.
    function automatic logic [EDC_WIDTH-1:0] edc_of(input logic [DATA_WIDTH-1:0] d);
        logic [R-1:0] s;
        s = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (d[i]) s = s ^ R'(pos_of(i));
        end
        return {^{d, s}, s};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] flip_data(
        input logic [DATA_WIDTH-1:0] d,
        input logic [R-1:0]          syn
    );
        logic [DATA_WIDTH-1:0] f;
        f = d;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (pos_of(i) == int'(syn)) f[i] = ~d[i];
        end
        return f;
    endfunction

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PW-1:0]         period_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [EDC_WIDTH-1:0]  redc_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [EDC_WIDTH-1:0]  wedc_q;
    logic [CNT_WIDTH-1:0]  corr_count;
    logic [CNT_WIDTH-1:0]  uncorr_count;
    logic                  uncorr_irq;
    logic [ADDR_WIDTH-1:0] uncorr_addr;
    logic                  pass_done;

    logic [EDC_WIDTH-1:0]  calc_edc;
    logic [R-1:0]          syn;
    logic                  par;
    logic                  is_single;
    logic                  is_uncorr;
    logic [DATA_WIDTH-1:0] fixed_data;
    logic [EDC_WIDTH-1:0]  fixed_edc;

    always_comb begin
        calc_edc   = edc_of(rdata_q);
        syn        = calc_edc[R-1:0] ^ redc_q[R-1:0];
        par        = ^{rdata_q, redc_q};
        // syn==0 with odd parity is an edc[r] flip: still a single error
        is_single  = par && (int'(syn) <= N);
        is_uncorr  = (par && (int'(syn) > N)) || (!par && (syn != '0));
        fixed_data = flip_data(rdata_q, syn);
        fixed_edc  = edc_of(fixed_data);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_busy    = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_enable) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b0;
                if (!i_enable)
                    state_nxt = S_IDLE;
                else if (i_start || (period_cnt == PERIOD_LAST))
                    state_nxt = S_RD_REQ;
            end
            S_RD_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_mem_rvalid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                state_nxt = is_single ? S_WR_REQ : S_NEXT;
            end
            S_WR_REQ: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                if (i_mem_gnt) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = i_enable ? S_WAIT : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr         <= '0;
            period_cnt   <= '0;
            rdata_q      <= '0;
            redc_q       <= '0;
            wdata_q      <= '0;
            wedc_q       <= '0;
            corr_count   <= '0;
            uncorr_count <= '0;
            uncorr_irq   <= 1'b0;
            uncorr_addr  <= '0;
            pass_done    <= 1'b0;
        end else begin
            uncorr_irq <= 1'b0;
            pass_done  <= 1'b0;
            if (state == S_WAIT) period_cnt <= period_cnt + 1'b1;
            else                 period_cnt <= '0;
            if (state == S_RD_WAIT && i_mem_rvalid) begin
                rdata_q <= i_mem_rdata;
                redc_q  <= i_mem_redc;
            end
            if (state == S_CHECK && is_single) begin
                wdata_q <= fixed_data;
                wedc_q  <= fixed_edc;
                if (corr_count != '1) corr_count <= corr_count + 1'b1;
            end
            if (state == S_CHECK && is_uncorr) begin
                uncorr_irq  <= 1'b1;
                uncorr_addr <= addr;
                if (uncorr_count != '1) uncorr_count <= uncorr_count + 1'b1;
            end
            if (state == S_NEXT) begin
                addr <= addr + 1'b1;
                if (addr == '1) pass_done <= 1'b1;
            end
        end
    end

    assign o_mem_addr     = addr;
    assign o_mem_wdata    = wdata_q;
    assign o_mem_wedc     = wedc_q;
    assign o_pass_done    = pass_done;
    assign o_corr_count   = corr_count;
    assign o_uncorr_count = uncorr_count;
    assign o_uncorr_irq   = uncorr_irq;
    assign o_uncorr_addr  = uncorr_addr;

endmodule

// File: tb/tb_ecc_ehc_scrubber.sv
// Scoreboard bench for ecc_ehc_scrubber with a 16-word memory model.
// Expected requests/irqs are queued; a monitor pops and compares them.
module tb_ecc_ehc_scrubber;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int EW  = 7;
    localparam int CW  = 2;
    localparam int PER = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          gnt = 1'b1;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [EW-1:0] redc = '0;
    logic          req;
    logic          we;
    logic [AW-1:0] maddr;
    logic [DW-1:0] wdata;
    logic [EW-1:0] wedc;
    logic          busy;
    logic          pass_done;
    logic [CW-1:0] corr;
    logic [CW-1:0] uncorr;
    logic          irq;
    logic [AW-1:0] uaddr;

    always #5 clk = ~clk;

    ecc_ehc_scrubber #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SCRUB_PERIOD(PER),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_start       (start),
        .o_mem_req     (req),
        .o_mem_we      (we),
        .o_mem_addr    (maddr),
        .o_mem_wdata   (wdata),
        .o_mem_wedc    (wedc),
        .i_mem_gnt     (gnt),
        .i_mem_rvalid  (rvalid),
        .i_mem_rdata   (rdata),
        .i_mem_redc    (redc),
        .o_busy        (busy),
        .o_pass_done   (pass_done),
        .o_corr_count  (corr),
        .o_uncorr_count(uncorr),
        .o_uncorr_irq  (irq),
        .o_uncorr_addr (uaddr)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic [EW-1:0] e;
    } txn_t;

    txn_t          exp_q[$];
    logic [AW-1:0] irq_q[$];
    logic [DW-1:0] mem_d[16];
    logic [EW-1:0] mem_e[16];
    logic [DW-1:0] err_d[16];
    logic [EW-1:0] err_e[16];
    int            total = 0;
    int            bad = 0;
    int            pass_cnt = 0;
    int            rv_delay = 1;
    logic [AW-1:0] last_rd = '0;

    // Walk codeword positions, skipping powers of two, XOR in each set bit's position.
    function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
        logic [5:0] syn;
        int         pos;
        syn = '0;
        pos = 0;
        for (int i = 0; i < DW; i++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) syn = syn ^ 6'(pos);
        end
        return {^{d, syn}, syn};
    endfunction

    function automatic logic [DW-1:0] gold(input int a);
        return 32'h5A3C_96E1 ^ (32'(a) * 32'h1357_9BDF);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        bad++;
        $display("FAIL %s got=%0h required=%0h", name, got, exp);
    endtask

    // Memory responder: grant follows gnt, read data after rv_delay cycles.
    initial begin
        int            cnt;
        logic          pend;
        logic [AW-1:0] pa;
        cnt  = 0;
        pend = 1'b0;
        pa   = '0;
        forever begin
            @(negedge clk);
            rvalid = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    rvalid = 1'b1;
                    rdata  = mem_d[pa];
                    redc   = mem_e[pa];
                    pend   = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (req && gnt) begin
                if (we) begin
                    mem_d[maddr] = wdata;
                    mem_e[maddr] = wedc;
                end else begin
                    pend = 1'b1;
                    cnt  = rv_delay;
                    pa   = maddr;
                end
            end
        end
    end

    // Monitor: every accepted request, irq and pass pulse is checked here.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (req && gnt) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_req", {we, maddr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_we", we, e.we);
                    chk("req_addr", maddr, e.addr);
                    if (e.we) begin
                        chk("wr_data", wdata, e.d);
                        chk("wr_edc", wedc, e.e);
                    end else begin
                        last_rd = maddr;
                    end
                end
            end
            if (irq) begin
                if (irq_q.size() == 0) fail("unexpected_irq", uaddr, 0);
                else chk("irq_addr", uaddr, irq_q.pop_front());
            end
            if (pass_done) begin
                pass_cnt++;
                chk("pass_last_addr", last_rd, 15);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        enable   = 1'b0;
        start    = 1'b0;
        gnt      = 1'b1;
        rv_delay = 1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_q.delete();
        irq_q.delete();
        pass_cnt = 0;
    endtask

    task automatic clear_err();
        for (int a = 0; a < 16; a++) begin
            err_d[a] = '0;
            err_e[a] = '0;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_flags"}, {we, pass_done, irq}, 0);
        chk({tag, "_counts"}, {corr, uncorr}, 0);
        chk({tag, "_uaddr"}, uaddr, 0);
        chk({tag, "_maddr"}, maddr, 0);
        chk({tag, "_wr"}, {wdata, wedc}, 0);
    endtask

    // Loads memory with golden words plus err masks, queues the expected
    // traffic for one full pass and runs it.
    task automatic run_pass(input string tag);
        int            ns;
        int            nu;
        int            w;
        int            n;
        logic [AW-1:0] lu;
        ns = 0;
        nu = 0;
        lu = '0;
        for (int a = 0; a < 16; a++) begin
            mem_d[a] = gold(a) ^ err_d[a];
            mem_e[a] = enc(gold(a)) ^ err_e[a];
            exp_q.push_back('{we: 1'b0, addr: AW'(a), d: '0, e: '0});
            w = $countones({err_d[a], err_e[a]});
            if (w == 1) begin
                exp_q.push_back('{we: 1'b1, addr: AW'(a), d: gold(a), e: enc(gold(a))});
                ns++;
            end else if (w == 2) begin
                irq_q.push_back(AW'(a));
                nu++;
                lu = AW'(a);
            end
        end
        pass_cnt = 0;
        enable   = 1'b1;
        n = 0;
        while (pass_cnt == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (pass_cnt == 0) fail({tag, "_pass_timeout"}, n, 0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (12) @(negedge clk);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_pass_pulses"}, pass_cnt, 1);
        chk({tag, "_corr"}, corr, (ns > 3) ? 3 : ns);
        chk({tag, "_uncorr"}, uncorr, (nu > 3) ? 3 : nu);
        chk({tag, "_req_left"}, exp_q.size(), 0);
        chk({tag, "_irq_left"}, irq_q.size(), 0);
        if (nu > 0) chk({tag, "_uaddr"}, uaddr, lu);
    endtask

    initial begin
        int n;
        clear_err();
        for (int a = 0; a < 16; a++) begin
            mem_d[a] = gold(a);
            mem_e[a] = enc(gold(a));
        end
        do_reset();
        @(negedge clk);
        chk_idle("reset");

        // clean memory
        run_pass("clean");

        // edc[6] at 2, data[5] at 3, data[1:0] at 7
        clear_err();
        do_reset();
        err_e[2] = 7'h40;
        err_d[3] = 32'h0000_0020;
        err_d[7] = 32'h0000_0003;
        run_pass("mixed");

        // five singles, four doubles: both counters saturate
        clear_err();
        do_reset();
        err_d[1]  = 32'h8000_0000;
        err_e[4]  = 7'h01;
        err_d[6]  = 32'h0002_0000;
        err_e[9]  = 7'h08;
        err_d[12] = 32'h0000_0001;
        err_e[0]  = 7'h41;
        err_d[13] = 32'h0000_0100;
        err_e[13] = 7'h04;
        err_d[14] = 32'h0000_0300;
        err_d[15] = 32'h8000_0001;
        run_pass("sat");

        // grant stall, then reset while waiting for read data
        clear_err();
        do_reset();
        for (int a = 0; a < 16; a++) begin
            mem_d[a] = gold(a);
            mem_e[a] = enc(gold(a));
        end
        exp_q.push_back('{we: 1'b0, addr: '0, d: '0, e: '0});
        gnt    = 1'b0;
        enable = 1'b1;
        for (n = 0; n < 50 && !req; n++) @(negedge clk);
        chk("stall_req_seen", req, 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_req", req, 1);
            chk("stall_we", we, 0);
            chk("stall_addr", maddr, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rv_delay = 3;
        gnt      = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle("rd_wait_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_rvalid_busy", busy, 0);
            chk("late_rvalid_req", req, 0);
            chk("late_rvalid_cnt", {corr, uncorr}, 0);
        end
        chk("stall_req_left", exp_q.size(), 0);

        // i_start in WAIT issues the read on the next cycle
        do_reset();
        exp_q.push_back('{we: 1'b0, addr: '0, d: '0, e: '0});
        enable = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("start_req", req, 1);
        chk("start_we", we, 0);
        for (n = 0; n < 50 && busy; n++) @(negedge clk);
        chk("start_idle", busy, 0);
        chk("start_next_addr", maddr, 1);
        chk("start_req_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
